// File: rtl/smd_frame_sync.sv
// Mega Drive six-button read-cycle sequencer: synchronises the select line, tracks the
// phase within a read burst, and commits host button words only between bursts.
module smd_frame_sync #(
    parameter int TIMEOUT_CYCLES = 15000,
    parameter int CNT_W          = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p7,
    input  logic [11:0] btn_in,
    input  logic        btn_valid,
    output logic        btn_ready,
    output logic [11:0] btn_out,
    output logic        p7_s,
    output logic [2:0]  phase,
    output logic        idle,
    output logic        pending
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic             sync1_r;
    logic             sync2_r;
    logic             p7_d_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [2:0]       phase_r;
    logic             idle_r;
    logic             pending_r;
    logic             btn_ready_r;
    logic [11:0]      shadow_r;
    logic [11:0]      btn_out_r;
    logic             transition_s;
    logic             timeout_s;
    logic             transfer_s;
    logic             commit_s;

    // Edge detect, saturating gap counter and handshake qualifiers.
    always_comb begin
        transition_s = sync2_r ^ p7_d_r;
        timeout_s    = (cnt_r == TIMEOUT_VAL);
        transfer_s   = btn_valid && btn_ready_r;
        commit_s     = idle_r && pending_r;
        if (transition_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (timeout_s) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Two-flop synchroniser plus a delayed copy for transition detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            p7_d_r  <= 1'b1;
        end else begin
            sync1_r <= p7;
            sync2_r <= sync1_r;
            p7_d_r  <= sync2_r;
        end
    end

    // Gap counter, burst phase and idle flag; idle is the registered form of
    // (counter at timeout && select high), so it drops one edge after p7_s falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            phase_r <= 3'd0;
            idle_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            idle_r <= (cnt_next_s == TIMEOUT_VAL) && sync2_r;
            if (transition_s) begin
                phase_r <= (phase_r == 3'd7) ? 3'd7 : phase_r + 3'd1;
            end else if (timeout_s) begin
                phase_r <= 3'd0;
            end else begin
                phase_r <= phase_r;
            end
        end
    end

    // One-deep shadow register; its word reaches btn_out only in an idle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r    <= 12'hFFF;
            btn_out_r   <= 12'hFFF;
            pending_r   <= 1'b0;
            btn_ready_r <= 1'b1;
        end else if (commit_s) begin
            btn_out_r   <= shadow_r;
            pending_r   <= 1'b0;
            btn_ready_r <= 1'b1;
        end else if (transfer_s) begin
            shadow_r    <= btn_in;
            pending_r   <= 1'b1;
            btn_ready_r <= 1'b0;
        end else begin
            shadow_r    <= shadow_r;
            pending_r   <= pending_r;
            btn_ready_r <= btn_ready_r;
        end
    end

    assign p7_s      = sync2_r;
    assign phase     = phase_r;
    assign idle      = idle_r;
    assign pending   = pending_r;
    assign btn_ready = btn_ready_r;
    assign btn_out   = btn_out_r;

endmodule

// File: tb/tb_smd_frame_sync.sv
// Self-checking bench for smd_frame_sync: directed test-plan scenarios plus random
// bursts, compared every cycle against an elapsed-time reference model.
module tb_smd_frame_sync;

    localparam int TO = 400;
    localparam int CW = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p7;
    logic [11:0] btn_in;
    logic        btn_valid;
    logic        btn_ready;
    logic [11:0] btn_out;
    logic        p7_s;
    logic [2:0]  phase;
    logic        idle;
    logic        pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: edges since reset, p7 sample history, last transition edge.
    int          mk;
    logic        p7_hist[$];
    int          m_last;
    logic [2:0]  m_phase;
    logic        m_idle;
    logic        m_pend;
    logic [11:0] m_shadow;
    logic [11:0] m_out;
    logic        p7_lvl;

    smd_frame_sync #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p7       (p7),
        .btn_in   (btn_in),
        .btn_valid(btn_valid),
        .btn_ready(btn_ready),
        .btn_out  (btn_out),
        .p7_s     (p7_s),
        .phase    (phase),
        .idle     (idle),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic logic p7_at(int i);
        if (i < 1) return 1'b1;
        return p7_hist[i-1];
    endfunction

    function automatic int gap(int k);
        int d;
        d = k - m_last;
        return (d > TO) ? TO : d;
    endfunction

    task automatic model_reset();
        mk = 0;
        p7_hist.delete();
        m_last   = 0;
        m_phase  = 3'd0;
        m_idle   = 1'b0;
        m_pend   = 1'b0;
        m_shadow = 12'hFFF;
        m_out    = 12'hFFF;
    endtask

    task automatic model_edge(input logic p7v, input logic vld, input logic [11:0] w);
        int   prev_gap;
        logic prev_idle;
        logic prev_pend;
        logic trans;
        prev_gap  = gap(mk);
        prev_idle = m_idle;
        prev_pend = m_pend;
        mk++;
        p7_hist.push_back(p7v);
        // The select change sampled two edges earlier becomes visible as a transition now.
        trans = (p7_at(mk-2) != p7_at(mk-3));
        if (trans) begin
            m_last  = mk;
            m_phase = (m_phase == 3'd7) ? 3'd7 : m_phase + 3'd1;
        end else if (prev_gap == TO) begin
            m_phase = 3'd0;
        end
        m_idle = (gap(mk) == TO) && p7_at(mk-2);
        if (prev_idle && prev_pend) begin
            m_out  = m_shadow;
            m_pend = 1'b0;
        end else if (vld && !prev_pend) begin
            m_shadow = w;
            m_pend   = 1'b1;
        end
    endtask

    task automatic check_all();
        check_eq("btn_out",   btn_out,   m_out);
        check_eq("btn_ready", btn_ready, !m_pend);
        check_eq("pending",   pending,   m_pend);
        check_eq("p7_s",      p7_s,      p7_at(mk-1));
        check_eq("phase",     phase,     m_phase);
        check_eq("idle",      idle,      m_idle);
    endtask

    // Called just after a falling edge: drive, take one rising edge, check on the next fall.
    task automatic step(input logic p7v, input logic vld, input logic [11:0] w);
        p7        = p7v;
        btn_valid = vld;
        btn_in    = w;
        @(posedge clk);
        model_edge(p7v, vld, w);
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step(p7_lvl, 1'b0, 12'h000);
    endtask

    // mode 0: no words, 1: word w after the 2nd fall then 000 held off, 2: random words.
    task automatic burst(input int n, input int hp, input int mode, input logic [11:0] w);
        int   falls;
        logic sent;
        logic vld;
        logic [11:0] wd;
        falls = 0;
        sent  = 1'b0;
        for (int t = 0; t < n; t++) begin
            p7_lvl = ~p7_lvl;
            if (!p7_lvl) falls++;
            for (int c = 0; c < hp; c++) begin
                vld = 1'b0;
                wd  = 12'h000;
                if (mode == 1 && falls >= 2) begin
                    vld = 1'b1;
                    wd  = sent ? 12'h000 : w;
                    sent = 1'b1;
                end else if (mode == 2) begin
                    vld = ($urandom_range(0, 7) == 0);
                    wd  = 12'($urandom_range(0, 4095));
                end
                step(p7_lvl, vld, wd);
                if (mode != 2 && t == 0 && c == 2) check_eq("idle_fall_3clk", idle, 1'b0);
                if (mode == 1 && sent) check_eq("hold_off_ready", btn_ready, 1'b0);
            end
        end
        if (n >= 8) check_eq("phase_sat7", phase, 3'd7);
    endtask

    initial begin
        rst_n     = 1'b0;
        p7        = 1'b1;
        p7_lvl    = 1'b1;
        btn_valid = 1'b0;
        btn_in    = 12'h000;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_btn_out", btn_out, 12'hFFF);
        check_eq("rst_ready",   btn_ready, 1'b1);
        check_eq("rst_idle",    idle, 1'b0);
        rst_n = 1'b1;

        // Idle rises exactly TO edges after release.
        for (int i = 1; i <= TO + 5; i++) begin
            step(1'b1, 1'b0, 12'h000);
            if (i == TO - 1) check_eq("idle_pre_timeout", idle, 1'b0);
            if (i == TO)     check_eq("idle_at_timeout",  idle, 1'b1);
        end
        check_eq("phase_idle0", phase, 3'd0);

        // Single transfer while idle.
        step(1'b1, 1'b1, 12'h7DF);
        check_eq("xfer_ready_low", btn_ready, 1'b0);
        step(1'b1, 1'b0, 12'h000);
        check_eq("xfer_commit", btn_out, 12'h7DF);
        check_eq("xfer_ready_back", btn_ready, 1'b1);
        wait_cycles(5);

        // Eight-transition burst, then timeout back to idle.
        burst(8, 130, 0, 12'h000);
        wait_cycles(TO + 10);
        check_eq("burst_idle_back", idle, 1'b1);
        check_eq("burst_phase0", phase, 3'd0);

        // Word sent mid-burst waits for the next idle window.
        burst(8, 130, 1, 12'hFFE);
        check_eq("mid_burst_hold", btn_out, 12'h7DF);
        wait_cycles(TO + 10);
        check_eq("mid_burst_commit", btn_out, 12'hFFE);

        // p7 held low past the timeout: phase clears, idle stays low, word stays pending.
        p7_lvl = 1'b0;
        wait_cycles(4);
        step(p7_lvl, 1'b1, 12'hABC);
        wait_cycles(TO + 140);
        check_eq("low_idle0", idle, 1'b0);
        check_eq("low_phase0", phase, 3'd0);
        check_eq("low_pending", pending, 1'b1);
        p7_lvl = 1'b1;
        wait_cycles(TO + 10);
        check_eq("low_commit", btn_out, 12'hABC);

        // Random bursts with random gaps, some too short to reach idle.
        for (int r = 0; r < 20; r++) begin
            burst($urandom_range(1, 12), $urandom_range(4, 40), 2, 12'h000);
            for (int g = $urandom_range(50, TO + 50); g > 0; g--) begin
                step(p7_lvl, ($urandom_range(0, 15) == 0), 12'($urandom_range(0, 4095)));
            end
        end
        if (!p7_lvl) begin
            p7_lvl = 1'b1;
        end
        wait_cycles(TO + 10);

        // Asynchronous reset mid-burst with a word pending.
        burst(3, 20, 0, 12'h000);
        step(p7_lvl, 1'b1, 12'h123);
        wait_cycles(3);
        check_eq("pre_rst_pending", pending, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_btn_out", btn_out, 12'hFFF);
        check_eq("arst_phase",   phase, 3'd0);
        check_eq("arst_idle",    idle, 1'b0);
        check_eq("arst_pending", pending, 1'b0);
        check_eq("arst_ready",   btn_ready, 1'b1);
        check_eq("arst_p7_s",    p7_s, 1'b1);
        p7     = 1'b1;
        p7_lvl = 1'b1;
        btn_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        wait_cycles(TO + 5);
        check_eq("post_rst_idle", idle, 1'b1);
        check_eq("post_rst_word_lost", btn_out, 12'hFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
